// File: rtl/alu_share_arbiter_if.sv
// Bundle of requester, response and ALU-side signals for alu_share_arbiter.
// The arbiter uses the slave modport; the requesters/ALU side uses master.
interface alu_share_arbiter_if #(
    parameter int DATA_W = 4,
    parameter int SEL_W  = 4,
    parameter int RES_W  = 8
);
    logic              req0_valid;
    logic              req0_ready;
    logic [DATA_W-1:0] req0_a;
    logic [DATA_W-1:0] req0_b;
    logic [SEL_W-1:0]  req0_sel;

    logic              req1_valid;
    logic              req1_ready;
    logic [DATA_W-1:0] req1_a;
    logic [DATA_W-1:0] req1_b;
    logic [SEL_W-1:0]  req1_sel;

    logic              rsp0_valid;
    logic              rsp1_valid;
    logic              rsp_ready;
    logic [RES_W-1:0]  rsp_data;
    logic              rsp_err;

    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [SEL_W-1:0]  alu_sel;
    logic [RES_W-1:0]  alu_c;

    logic              busy;

    modport master (
        output req0_valid, req0_a, req0_b, req0_sel,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_sel,
        input  req1_ready,
        input  rsp0_valid, rsp1_valid, rsp_data, rsp_err,
        output rsp_ready,
        input  alu_a, alu_b, alu_sel,
        output alu_c,
        input  busy
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_sel,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_sel,
        output req1_ready,
        output rsp0_valid, rsp1_valid, rsp_data, rsp_err,
        input  rsp_ready,
        output alu_a, alu_b, alu_sel,
        input  alu_c,
        output busy
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one external combinational ALU between two requesters.
// Optional macro OPCODE_CHECK_EN: illegal opcodes are rejected with rsp_err instead of issued.
module alu_share_arbiter #(
    parameter int DATA_W  = 4,
    parameter int SEL_W   = 4,
    parameter int RES_W   = 8,
    parameter int ALU_LAT = 1
) (
    input logic                clk,
    input logic                rst_n,
    alu_share_arbiter_if.slave bus
);
    localparam int CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t            state;
    logic              last_grant;
    logic              owner;
    logic [CNT_W-1:0]  wait_cnt;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [SEL_W-1:0]  alu_sel;
    logic [RES_W-1:0]  rsp_data;
    logic              rsp_err;
    logic              rsp0_valid;
    logic              rsp1_valid;
    logic              busy;

    logic              grant_vld;
    logic              grant;
    logic [DATA_W-1:0] grant_a;
    logic [DATA_W-1:0] grant_b;
    logic [SEL_W-1:0]  grant_sel;
    logic              op_legal;

`ifdef OPCODE_CHECK_EN
    function automatic logic legal_op(input logic [SEL_W-1:0] sel);
        case (sel)
            SEL_W'(0), SEL_W'(15), SEL_W'(1), SEL_W'(2), SEL_W'(4),
            SEL_W'(8), SEL_W'(3),  SEL_W'(6), SEL_W'(12), SEL_W'(5): return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    assign op_legal = legal_op(grant_sel);
`else
    assign op_legal = 1'b1;
`endif

    // Grant: a lone requester wins; on contention the one not served last wins.
    always_comb begin
        grant_vld = bus.req0_valid | bus.req1_valid;
        grant     = (bus.req0_valid && bus.req1_valid) ? ~last_grant : bus.req1_valid;
        grant_a   = grant ? bus.req1_a   : bus.req0_a;
        grant_b   = grant ? bus.req1_b   : bus.req0_b;
        grant_sel = grant ? bus.req1_sel : bus.req0_sel;
    end

    // Ready is gated by rst_n so every handshake output reads 0 while reset is held.
    assign bus.req0_ready = rst_n && (state == IDLE) && grant_vld && !grant;
    assign bus.req1_ready = rst_n && (state == IDLE) && grant_vld &&  grant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            wait_cnt   <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_sel    <= '0;
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        owner <= grant;
                        busy  <= 1'b1;
                        if (op_legal) begin
                            alu_a    <= grant_a;
                            alu_b    <= grant_b;
                            alu_sel  <= grant_sel;
                            wait_cnt <= CNT_W'(ALU_LAT - 1);
                            state    <= ISSUE;
                        end else begin
                            // Rejected op skips the ALU and leaves alu_* untouched.
                            rsp_data   <= '0;
                            rsp_err    <= 1'b1;
                            rsp0_valid <= ~grant;
                            rsp1_valid <= grant;
                            state      <= RESP;
                        end
                    end
                end
                ISSUE: begin
                    if (wait_cnt != '0) begin
                        wait_cnt <= wait_cnt - CNT_W'(1);
                    end else begin
                        rsp_data   <= bus.alu_c;
                        rsp_err    <= 1'b0;
                        rsp0_valid <= ~owner;
                        rsp1_valid <= owner;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        last_grant <= owner;
                        rsp0_valid <= 1'b0;
                        rsp1_valid <= 1'b0;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.alu_a      = alu_a;
    assign bus.alu_b      = alu_b;
    assign bus.alu_sel    = alu_sel;
    assign bus.rsp_data   = rsp_data;
    assign bus.rsp_err    = rsp_err;
    assign bus.rsp0_valid = rsp0_valid;
    assign bus.rsp1_valid = rsp1_valid;
    assign bus.busy       = busy;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: transaction-level model plus directed vectors on an
// ALU_LAT=1 instance, and directed latency vectors on an ALU_LAT=3 instance.
module tb_alu_share_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_share_arbiter_if #(.DATA_W(4), .SEL_W(4), .RES_W(8)) bus1 ();
    alu_share_arbiter_if #(.DATA_W(4), .SEL_W(4), .RES_W(8)) bus3 ();

    alu_share_arbiter #(.DATA_W(4), .SEL_W(4), .RES_W(8), .ALU_LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1));
    alu_share_arbiter #(.DATA_W(4), .SEL_W(4), .RES_W(8), .ALU_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .bus(bus3));

    // External ALU: add, sub, mul, and, or, xor; anything else yields 0.
    function automatic logic [7:0] alu_fn(input logic [3:0] a, input logic [3:0] b,
                                          input logic [3:0] s);
        case (s)
            4'b0000: return 8'(a) + 8'(b);
            4'b1111: return 8'(a) - 8'(b);
            4'b0101: return 8'(a) * 8'(b);
            4'b0001: return {4'h0, a & b};
            4'b0010: return {4'h0, a | b};
            4'b0100: return {4'h0, a ^ b};
            default: return 8'h00;
        endcase
    endfunction

    assign bus1.alu_c = alu_fn(bus1.alu_a, bus1.alu_b, bus1.alu_sel);
    assign bus3.alu_c = alu_fn(bus3.alu_a, bus3.alu_b, bus3.alu_sel);

    function automatic logic is_legal(input logic [3:0] s);
        int legal_ops[10] = '{0, 15, 1, 2, 4, 8, 3, 6, 12, 5};
        for (int i = 0; i < 10; i++)
            if (int'(s) == legal_ops[i]) return 1'b1;
        return 1'b0;
    endfunction

    int   checks = 0;
    int   errors = 0;
    logic chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model of the ALU_LAT=1 instance: one operation in flight at a time.
    logic       m_busy, m_resp, m_owner, m_last, m_err;
    logic [3:0] m_a, m_b, m_sel;
    logic [7:0] m_data;
    int         m_left;
    logic       m_gv, m_g;
    logic [3:0] m_ga, m_gb, m_gs;

    always_comb begin
        m_gv = bus1.req0_valid | bus1.req1_valid;
        m_g  = (bus1.req0_valid && bus1.req1_valid) ? !m_last : bus1.req1_valid;
        m_ga = m_g ? bus1.req1_a   : bus1.req0_a;
        m_gb = m_g ? bus1.req1_b   : bus1.req0_b;
        m_gs = m_g ? bus1.req1_sel : bus1.req0_sel;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0; m_resp <= 1'b0; m_owner <= 1'b0; m_last <= 1'b1;
            m_err <= 1'b0; m_a <= '0; m_b <= '0; m_sel <= '0; m_data <= '0; m_left <= 0;
        end else if (!m_busy) begin
            if (m_gv) begin
                m_busy  <= 1'b1;
                m_owner <= m_g;
`ifdef OPCODE_CHECK_EN
                if (!is_legal(m_gs)) begin
                    m_resp <= 1'b1; m_data <= 8'h00; m_err <= 1'b1;
                end else
`endif
                begin
                    m_a <= m_ga; m_b <= m_gb; m_sel <= m_gs; m_left <= 1; m_resp <= 1'b0;
                end
            end
        end else if (!m_resp) begin
            if (m_left <= 1) begin
                m_resp <= 1'b1; m_data <= alu_fn(m_a, m_b, m_sel); m_err <= 1'b0;
            end else begin
                m_left <= m_left - 1;
            end
        end else if (bus1.rsp_ready) begin
            m_busy <= 1'b0; m_resp <= 1'b0; m_last <= m_owner;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_busy",     32'(bus1.busy),       32'(m_busy));
            chk("m_req0_rdy", 32'(bus1.req0_ready), 32'(rst_n && !m_busy && m_gv && !m_g));
            chk("m_req1_rdy", 32'(bus1.req1_ready), 32'(rst_n && !m_busy && m_gv && m_g));
            chk("m_rsp0_vld", 32'(bus1.rsp0_valid), 32'(m_resp && !m_owner));
            chk("m_rsp1_vld", 32'(bus1.rsp1_valid), 32'(m_resp && m_owner));
            chk("m_alu_a",    32'(bus1.alu_a),      32'(m_a));
            chk("m_alu_b",    32'(bus1.alu_b),      32'(m_b));
            chk("m_alu_sel",  32'(bus1.alu_sel),    32'(m_sel));
            chk("m_rsp_data", 32'(bus1.rsp_data),   32'(m_data));
            chk("m_rsp_err",  32'(bus1.rsp_err),    32'(m_err));
        end
    end

    task automatic clear_inputs();
        bus1.req0_valid = 0; bus1.req0_a = 0; bus1.req0_b = 0; bus1.req0_sel = 0;
        bus1.req1_valid = 0; bus1.req1_a = 0; bus1.req1_b = 0; bus1.req1_sel = 0;
        bus1.rsp_ready  = 0;
        bus3.req0_valid = 0; bus3.req0_a = 0; bus3.req0_b = 0; bus3.req0_sel = 0;
        bus3.req1_valid = 0; bus3.req1_a = 0; bus3.req1_b = 0; bus3.req1_sel = 0;
        bus3.rsp_ready  = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int order[$];
        logic [7:0] datas[$];
        int n;
        logic got;

        clear_inputs();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        chk_en = 1'b1;
        #1;
        chk("rst_busy",     32'(bus1.busy),       32'(0));
        chk("rst_req0_rdy", 32'(bus1.req0_ready), 32'(0));
        chk("rst_rsp0_vld", 32'(bus1.rsp0_valid), 32'(0));
        chk("rst_rsp1_vld", 32'(bus1.rsp1_valid), 32'(0));
        chk("rst_alu_a",    32'(bus1.alu_a),      32'(0));
        chk("rst_alu_sel",  32'(bus1.alu_sel),    32'(0));
        chk("rst_rsp_data", 32'(bus1.rsp_data),   32'(0));
        chk("rst_rsp_err",  32'(bus1.rsp_err),    32'(0));
        @(posedge clk); #1 rst_n = 1'b1;

        // Contention: both held valid with rsp_ready high; alternation starts at req0.
        bus1.req0_valid = 1; bus1.req0_a = 2; bus1.req0_b = 1; bus1.req0_sel = 4'b0000;
        bus1.req1_valid = 1; bus1.req1_a = 2; bus1.req1_b = 1; bus1.req1_sel = 4'b1111;
        bus1.rsp_ready  = 1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus1.req0_valid && bus1.req0_ready) order.push_back(0);
            if (bus1.req1_valid && bus1.req1_ready) order.push_back(1);
            if (bus1.rsp0_valid || bus1.rsp1_valid) datas.push_back(bus1.rsp_data);
        end
        @(posedge clk); #1;
        clear_inputs();
        chk("rr_count", 32'(order.size()), 32'(4));
        chk("rr_dcount", 32'(datas.size()), 32'(4));
        for (int i = 0; i < 4 && i < order.size(); i++)
            chk("rr_order", 32'(order[i]), 32'(i % 2));
        for (int i = 0; i < 4 && i < datas.size(); i++)
            chk("rr_data", 32'(datas[i]), (i % 2 == 0) ? 32'h03 : 32'h01);

        // Single requester 0: 3+4 returned two cycles after the handshake.
        tick();
        bus1.req0_valid = 1; bus1.req0_a = 3; bus1.req0_b = 4; bus1.req0_sel = 4'b0000;
        @(negedge clk); chk("t1_req0_rdy", 32'(bus1.req0_ready), 32'(1));
        tick(); bus1.req0_valid = 0;
        @(negedge clk); chk("t1_rsp0_early", 32'(bus1.rsp0_valid), 32'(0));
        tick();
        @(negedge clk);
        chk("t1_rsp0_vld", 32'(bus1.rsp0_valid), 32'(1));
        chk("t1_rsp1_vld", 32'(bus1.rsp1_valid), 32'(0));
        chk("t1_data",     32'(bus1.rsp_data),   32'h07);
        bus1.rsp_ready = 1; tick(); bus1.rsp_ready = 0;

        // Requester 1 wins after req0 was served; response held 5 cycles under backpressure.
        bus1.req0_valid = 1; bus1.req0_a = 1;  bus1.req0_b = 1;  bus1.req0_sel = 4'b0000;
        bus1.req1_valid = 1; bus1.req1_a = 15; bus1.req1_b = 15; bus1.req1_sel = 4'b0101;
        @(negedge clk);
        chk("t3_req1_rdy", 32'(bus1.req1_ready), 32'(1));
        chk("t3_req0_rdy", 32'(bus1.req0_ready), 32'(0));
        tick(); bus1.req1_valid = 0;
        @(negedge clk); chk("t3_req0_issue", 32'(bus1.req0_ready), 32'(0));
        tick();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t3_rsp1_vld", 32'(bus1.rsp1_valid), 32'(1));
            chk("t3_data",     32'(bus1.rsp_data),   32'hE1);
            chk("t3_req0_rdy", 32'(bus1.req0_ready), 32'(0));
            tick();
        end
        bus1.rsp_ready = 1;
        @(negedge clk); chk("t3_rsp1_hold", 32'(bus1.rsp1_valid), 32'(1));
        tick(); bus1.rsp_ready = 0;
        @(negedge clk); chk("t3_req0_after", 32'(bus1.req0_ready), 32'(1));
        tick(); bus1.req0_valid = 0;
        tick();
        @(negedge clk);
        chk("t3_rsp0_vld", 32'(bus1.rsp0_valid), 32'(1));
        chk("t3_data0",    32'(bus1.rsp_data),   32'h02);
        bus1.rsp_ready = 1; tick(); bus1.rsp_ready = 0;

        // Opcode 0111: rejected when the check is built in, otherwise passed to the ALU.
        bus1.req0_valid = 1; bus1.req0_a = 1; bus1.req0_b = 2; bus1.req0_sel = 4'b0111;
        @(negedge clk); chk("t4_req0_rdy", 32'(bus1.req0_ready), 32'(1));
        tick(); bus1.req0_valid = 0;
        n = 0; got = 0;
        for (int i = 0; i < 4 && !got; i++) begin
            @(negedge clk);
            if (bus1.rsp0_valid) got = 1; else n++;
        end
        chk("t4_got", 32'(got), 32'(1));
        chk("t4_data", 32'(bus1.rsp_data), 32'h00);
`ifdef OPCODE_CHECK_EN
        chk("t4_lat", 32'(n), 32'(0));
        chk("t4_err", 32'(bus1.rsp_err), 32'(1));
        chk("t4_alu_sel", 32'(bus1.alu_sel), 32'(0));
`else
        chk("t4_lat", 32'(n), 32'(1));
        chk("t4_err", 32'(bus1.rsp_err), 32'(0));
        chk("t4_alu_sel", 32'(bus1.alu_sel), 32'(7));
`endif
        bus1.rsp_ready = 1; tick(); bus1.rsp_ready = 0;

        // Reset mid-ISSUE: outputs clear immediately, transaction is lost.
        bus1.req1_valid = 1; bus1.req1_a = 3; bus1.req1_b = 3; bus1.req1_sel = 4'b0000;
        tick(); bus1.req1_valid = 0;
        #2 rst_n = 1'b0;
        #1;
        chk("t5_busy",  32'(bus1.busy),       32'(0));
        chk("t5_alu_a", 32'(bus1.alu_a),      32'(0));
        chk("t5_alu_b", 32'(bus1.alu_b),      32'(0));
        chk("t5_rsp1",  32'(bus1.rsp1_valid), 32'(0));
        chk("t5_data",  32'(bus1.rsp_data),   32'(0));
        @(posedge clk); #1 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); chk("t5_no_rsp", 32'(bus1.rsp1_valid), 32'(0));
            tick();
        end
        bus1.req0_valid = 1; bus1.req0_a = 4; bus1.req0_b = 4; bus1.req0_sel = 4'b0000;
        bus1.req1_valid = 1; bus1.req1_a = 4; bus1.req1_b = 4; bus1.req1_sel = 4'b0000;
        @(negedge clk);
        chk("t5_req0_rdy", 32'(bus1.req0_ready), 32'(1));
        chk("t5_req1_rdy", 32'(bus1.req1_ready), 32'(0));
        tick(); bus1.req0_valid = 0; bus1.req1_valid = 0; bus1.rsp_ready = 1;
        tick(); tick(); tick();
        bus1.rsp_ready = 0;

        // ALU_LAT=3 instance: operands held three cycles, response on the fourth.
        bus3.req0_valid = 1; bus3.req0_a = 6; bus3.req0_b = 5; bus3.req0_sel = 4'b1111;
        @(negedge clk); chk("t6_req0_rdy", 32'(bus3.req0_ready), 32'(1));
        tick(); bus3.req0_valid = 0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk("t6_alu_a",   32'(bus3.alu_a),      32'(6));
            chk("t6_alu_b",   32'(bus3.alu_b),      32'(5));
            chk("t6_alu_sel", 32'(bus3.alu_sel),    32'hF);
            chk("t6_rsp0_early", 32'(bus3.rsp0_valid), 32'(0));
            tick();
        end
        @(negedge clk);
        chk("t6_rsp0_vld", 32'(bus3.rsp0_valid), 32'(1));
        chk("t6_data",     32'(bus3.rsp_data),   32'h01);
        chk("t6_busy",     32'(bus3.busy),       32'(1));
        bus3.rsp_ready = 1; tick(); bus3.rsp_ready = 0;
        @(negedge clk);
        chk("t6_busy_end", 32'(bus3.busy),       32'(0));
        chk("t6_rsp0_end", 32'(bus3.rsp0_valid), 32'(0));

        tick(); tick();
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
